// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive front end: FSM encoding,
// error cause codes and the scan-code set 2 prefix bytes.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_PARITY  = 2'b01;
    localparam logic [1:0] ERR_FRAME   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;

    // Odd parity over data plus parity bit means the frame is intact.
    function automatic logic parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Synchroniser and glitch filter for the raw PS/2 pins. Produces the
// filtered clock level, the synchronised data level and a one-cycle pulse
// in the cycle the filtered clock falls. SYNC_STAGES must be at least 2.
module ps2_sync_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_filt,
    output logic data_sync,
    output logic fall
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] clk_chain;
    logic [SYNC_STAGES-1:0] data_chain;
    logic [CNT_W-1:0]       cnt;
    logic                   clk_s;

    assign clk_s     = clk_chain[SYNC_STAGES-1];
    assign data_sync = data_chain[SYNC_STAGES-1];

    // Synchroniser chains; both idle high like an undriven PS/2 bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_chain  <= '1;
            data_chain <= '1;
        end else begin
            clk_chain  <= {clk_chain[SYNC_STAGES-2:0], ps2_clk};
            data_chain <= {data_chain[SYNC_STAGES-2:0], ps2_data};
        end
    end

    // Accept a clock level change only after FILTER_LEN consecutive
    // differing samples; any sample matching the current level restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            clk_filt <= 1'b1;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_s == clk_filt) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
                cnt      <= '0;
                clk_filt <= clk_s;
                fall     <= clk_filt;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: deserialises 11-bit frames into bytes,
// flags parity/framing/timeout errors and folds E0/F0 prefixes into
// single key events.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic [1:0] err_type,
    output logic [7:0] key_code,
    output logic       key_valid,
    output logic       key_release,
    output logic       key_extended
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

    // Filtered clock level is not needed here; only its falling edge is.
    logic clk_filt_unused;
    logic data_s;
    logic fall;

    state_t     state, state_nxt;
    logic [7:0] shift, shift_nxt;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic       par, par_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic       tmo_hit;
    logic       valid_nxt;
    logic       err_nxt;
    logic [1:0] etype_nxt;
    logic       ext_flag;
    logic       rel_flag;

    ps2_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_sync_filter (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .clk_filt  (clk_filt_unused),
        .data_sync (data_s),
        .fall      (fall)
    );

    // A fall on the same cycle wins over the timeout, since it restarts the count.
    assign tmo_hit = (state != ST_IDLE) && !fall &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // Timeout counter: idle and every clock fall restart the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == ST_IDLE || fall || tmo_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Frame FSM state and deserialiser registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            par     <= 1'b0;
        end else begin
            state   <= state_nxt;
            shift   <= shift_nxt;
            bit_cnt <= bit_cnt_nxt;
            par     <= par_nxt;
        end
    end

    // Next-state logic and frame completion/error decisions.
    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift;
        bit_cnt_nxt = bit_cnt;
        par_nxt     = par;
        valid_nxt   = 1'b0;
        err_nxt     = 1'b0;
        etype_nxt   = ERR_NONE;
        case (state)
            ST_IDLE: begin
                if (fall && !data_s) begin
                    state_nxt   = ST_DATA;
                    bit_cnt_nxt = '0;
                end
            end
            ST_DATA: begin
                if (fall) begin
                    shift_nxt   = {data_s, shift[7:1]};
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (fall) begin
                    par_nxt   = data_s;
                    state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall) begin
                    state_nxt = ST_IDLE;
                    if (!data_s) begin
                        err_nxt   = 1'b1;
                        etype_nxt = ERR_FRAME;
                    end else if (!parity_ok(shift, par)) begin
                        err_nxt   = 1'b1;
                        etype_nxt = ERR_PARITY;
                    end else begin
                        valid_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (tmo_hit) begin
            state_nxt = ST_IDLE;
            err_nxt   = 1'b1;
            etype_nxt = ERR_TIMEOUT;
        end
    end

    // Byte-level outputs, registered one cycle after the stop-bit edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            err_type <= ERR_NONE;
        end else begin
            rx_valid <= valid_nxt;
            rx_err   <= err_nxt;
            if (valid_nxt) begin
                rx_data <= shift;
            end
            if (err_nxt) begin
                err_type <= etype_nxt;
            end
        end
    end

    // Scan-code decoder: prefixes set sticky flags, any other byte emits an event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_flag     <= 1'b0;
            rel_flag     <= 1'b0;
            key_valid    <= 1'b0;
            key_code     <= '0;
            key_release  <= 1'b0;
            key_extended <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (rx_err) begin
                ext_flag <= 1'b0;
                rel_flag <= 1'b0;
            end else if (rx_valid) begin
                if (rx_data == SC_EXT) begin
                    ext_flag <= 1'b1;
                end else if (rx_data == SC_BREAK) begin
                    rel_flag <= 1'b1;
                end else begin
                    key_valid    <= 1'b1;
                    key_code     <= rx_data;
                    key_release  <= rel_flag;
                    key_extended <= ext_flag;
                    ext_flag     <= 1'b0;
                    rel_flag     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx.sv
// Scoreboard bench for ps2_rx: stimulus pushes expected byte/key events
// from a frame-level reference model, a monitor pops them on DUT pulses.
module tb_ps2_rx;

    localparam int H   = 10;   // PS/2 half bit period in clk cycles
    localparam int TMO = 400;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        logic [1:0] etype;
    } rx_exp_t;

    typedef struct {
        logic [7:0] code;
        bit         rel;
        bit         ext;
    } key_exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic [1:0] err_type;
    logic [7:0] key_code;
    logic       key_valid;
    logic       key_release;
    logic       key_extended;

    rx_exp_t  rxq[$];
    key_exp_t keyq[$];
    bit       m_ext = 0;
    bit       m_rel = 0;
    int       n_cmp = 0;
    int       n_fail = 0;
    logic     rx_valid_prev = 1'b0;

    ps2_rx #(
        .SYNC_STAGES    (2),
        .FILTER_LEN     (4),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_err       (rx_err),
        .err_type     (err_type),
        .key_code     (key_code),
        .key_valid    (key_valid),
        .key_release  (key_release),
        .key_extended (key_extended)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: what one frame should produce, from the protocol rules.
    task automatic model_error(input logic [1:0] et);
        rxq.push_back('{1'b1, 8'h00, et});
        m_ext = 0;
        m_rel = 0;
    endtask

    task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        if (bad_stop) begin
            model_error(2'b10);
        end else if (bad_par) begin
            model_error(2'b01);
        end else begin
            rxq.push_back('{1'b0, b, 2'b00});
            if (b == 8'hE0) m_ext = 1;
            else if (b == 8'hF0) m_rel = 1;
            else begin
                keyq.push_back('{b, m_rel, m_ext});
                m_ext = 0;
                m_rel = 0;
            end
        end
    endtask

    task automatic drive_bit(input logic v, input bit glitch);
        @(negedge clk);
        ps2_data = v;
        if (glitch) begin
            repeat (4) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (2) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (H - 6) @(negedge clk);
        end else begin
            repeat (H) @(negedge clk);
        end
        ps2_clk = 1'b0;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    // Drive the first nbits bits of a frame; glitch_bit < 0 means no glitch.
    task automatic drive_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                               input int nbits, input int glitch_bit);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) drive_bit(bits[i], i == glitch_bit);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (3 * H) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        model_frame(b, bad_par, bad_stop);
        drive_frame(b, bad_par, bad_stop, 11, -1);
    endtask

    // Monitor: every output pulse must match the head of its queue.
    always @(negedge clk) begin
        if (rx_valid || rx_err) begin
            check("rx_exclusive", {31'd0, rx_valid & rx_err}, 32'd0);
            if (rxq.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL rx_unexpected: got valid=%0b err=%0b data=%0h, expected no event",
                         rx_valid, rx_err, rx_data);
            end else begin
                rx_exp_t e;
                e = rxq.pop_front();
                check("rx_is_err", {31'd0, rx_err}, {31'd0, e.is_err});
                if (e.is_err) check("err_type", {30'd0, err_type}, {30'd0, e.etype});
                else          check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
            end
        end
        if (key_valid) begin
            check("key_latency", {31'd0, rx_valid_prev}, 32'd1);
            if (keyq.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL key_unexpected: got code=%0h, expected no event", key_code);
            end else begin
                key_exp_t k;
                k = keyq.pop_front();
                check("key_code", {24'd0, key_code}, {24'd0, k.code});
                check("key_release", {31'd0, key_release}, {31'd0, k.rel});
                check("key_extended", {31'd0, key_extended}, {31'd0, k.ext});
            end
        end
        rx_valid_prev <= rx_valid;
    end

    initial begin
        repeat (5) @(negedge clk);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_rx_err", {31'd0, rx_err}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_err_type", {30'd0, err_type}, 32'd0);
        check("rst_key", {21'd0, key_valid, key_code, key_release, key_extended}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Directed sequences
        send(8'h1C, 0, 0);
        send(8'hF0, 0, 0);
        send(8'h1C, 0, 0);
        send(8'hF0, 0, 0);
        send(8'hE0, 0, 0);
        send(8'hF0, 0, 0);
        send(8'h75, 0, 0);
        send(8'h1C, 0, 0);
        send(8'h1C, 1, 0);
        send(8'hF0, 0, 0);
        send(8'h1C, 1, 0);
        send(8'h1C, 0, 0);
        send(8'hE0, 0, 0);
        send(8'hE0, 0, 0);
        send(8'hF0, 0, 0);
        send(8'h6B, 0, 0);

        // Timeout on a partial frame, then a clean frame
        send(8'hF0, 0, 0);
        model_error(2'b11);
        drive_frame(8'h5A, 0, 0, 6, -1);
        repeat (TMO + 50) @(negedge clk);
        send(8'h1C, 0, 0);

        // Reset mid-frame drops the frame and the pending break prefix
        send(8'hF0, 0, 0);
        drive_frame(8'h33, 0, 0, 4, -1);
        rst = 1'b1;
        m_ext = 0;
        m_rel = 0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        send(8'h1C, 0, 0);

        // Clock glitch during data bits, and a framing error
        model_frame(8'hA5, 0, 0);
        drive_frame(8'hA5, 0, 0, 11, 3);
        send(8'h1C, 0, 1);
        send(8'h29, 0, 0);

        // Randomised frames
        for (int i = 0; i < 40; i++) begin
            logic [7:0] b;
            int r;
            int e;
            r = $urandom_range(0, 7);
            e = $urandom_range(0, 9);
            b = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom);
            send(b, e == 0, e == 1);
        end

        repeat (100) @(negedge clk);
        check("rxq_drained", rxq.size(), 32'd0);
        check("keyq_drained", keyq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
PS/2 keyboard receive front end for the arcade machine's input path. Synchronises and filters the raw ps2_clk/ps2_data pins and deserialises 11-bit device-to-host frames into bytes. Decodes the scan-code set 2 prefixes (E0 extended, F0 break) into single key events that feed the downstream key-state and control logic. Detects parity, framing and timeout errors.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the input synchronisers for both pins.
FILTER_LEN, 4, consecutive equal synchronised samples needed to accept a ps2_clk level change.
TIMEOUT_CYCLES, 50000, clk cycles without a ps2_clk falling edge before a partial frame is aborted (1 ms at 50 MHz).

Ports:
clk  in  1  system clock; all logic on its rising edge.
rst  in  1  asynchronous, active-high reset.
ps2_clk  in  1  raw PS/2 clock pin; asynchronous to clk.
ps2_data  in  1  raw PS/2 data pin; asynchronous to clk.
rx_data  out  8  last correctly received byte.
rx_valid  out  1  one-cycle pulse; rx_data is new.
rx_err  out  1  one-cycle pulse; frame discarded.
err_type  out  2  error cause, valid with rx_err: 01 parity, 10 framing (stop=0), 11 timeout.
key_code  out  8  scan code of the decoded key event.
key_valid  out  1  one-cycle pulse; key_code, key_release and key_extended are valid.
key_release  out  1  event is a break (F0 seen).
key_extended  out  1  event is extended (E0 seen).

Behaviour:
- Reset: all outputs 0, FSM in IDLE, shift register, bit counter, timeout counter and prefix flags cleared. Filtered ps2_clk resets to 1. Reset mid-frame drops the partial frame silently.
- Input path: each pin goes through SYNC_STAGES flops. The filtered ps2_clk changes level only after FILTER_LEN identical samples. A falling edge is filtered clk going 1->0. ps2_data is sampled from its synchronised value in the cycle of that edge.
- FSM states: IDLE, DATA, PARITY, STOP.
- IDLE: on an edge with data=0 (start bit), go to DATA with bit count 0. An edge with data=1 is ignored, with no error.
- DATA: on each edge, shift data in LSB first. After the 8th bit, go to PARITY.
- PARITY: on the edge, latch the parity bit and go to STOP.
- STOP, on the edge:
  - Stop bit 0: rx_err=1, err_type=10.
  - Otherwise, the count of ones across the 8 data bits plus the parity bit must be odd. If not: rx_err=1, err_type=01.
  - Otherwise: rx_data is updated and rx_valid=1.
  - Always return to IDLE.
- Latency: rx_valid or rx_err is high in the cycle after the clk cycle that detects the stop-bit edge, for exactly one cycle.
- Timeout: the counter clears on every falling edge and in IDLE, and increments otherwise. On reaching TIMEOUT_CYCLES-1 outside IDLE, the FSM returns to IDLE with rx_err=1, err_type=11. Counter width is clog2(TIMEOUT_CYCLES).
- rx_valid and rx_err are never high together.
- Decoder, acting on rx_valid:
  - Byte E0: set ext flag, no key_valid.
  - Byte F0: set rel flag, no key_valid.
  - Any other byte: key_valid=1 one cycle after rx_valid, with key_code=byte, key_release=rel and key_extended=ext; both flags then clear.
  - key_code, key_release and key_extended hold their values until the next key_valid.
  - Any rx_err clears both flags.
- Repeated prefixes are idempotent (E0 E0 F0 x gives one extended break event).
- No host-to-device transmission. The block never drives the pins.

Decomposition:
- Shared package ps2_pkg: state encoding, err_type codes (ERR_PARITY, ERR_FRAME, ERR_TIMEOUT), and scan constants SC_EXT=8'hE0 and SC_BREAK=8'hF0.
- One sub-module, ps2_sync_filter: synchroniser plus glitch filter. It takes the raw pins and produces the filtered clk, the synchronised data and a one-cycle fall pulse. It is instantiated once.

Test Plan:
- Reset, then frame 0x1C (bits 0 0 1 1 1 0 0 0, parity 0, stop 1) -> rx_valid pulse, rx_data=1C; next cycle key_valid=1, key_code=1C, key_release=0, key_extended=0.
- Frames F0 (parity 1) then 1C -> exactly one key_valid, key_code=1C, key_release=1, key_extended=0; F0 alone gives rx_valid but no key_valid.
- Frames E0, F0, 75 (parities 0, 1, 0) -> one key_valid, key_code=75, key_release=1, key_extended=1; a following plain 1C gives both flags 0.
- Frame 1C with parity bit 1 -> rx_err=1, err_type=01, no rx_valid, no key_valid. Send F0 then the bad frame then 1C -> key_release=0, since the error cleared the flag.
- Start bit plus 5 data bits, then idle TIMEOUT_CYCLES -> rx_err, err_type=11, FSM in IDLE. A following clean 1C frame is received correctly. Separately, assert rst mid-frame -> no pulses, and the next frame decodes correctly.
- A 2-cycle low glitch on ps2_clk during DATA -> ignored, frame decodes unchanged. A frame with stop bit 0 -> rx_err, err_type=10.
